// File: rtl/li_expander.sv
// li_expander
// Expands a 32-bit constant plus a destination register into the RV32I
// instruction words that rebuild it (the `li` pseudo-instruction).
// A constant that fits in a signed 12-bit immediate becomes one addi.
// Any other constant becomes a lui, followed by an addi when its low 12 bits
// are non-zero. A request with rd = x0 becomes a single canonical nop.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   synchronous, active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   block can accept a request (high only when idle)
//   in_value   in   32  constant to load
//   in_rd      in   5   destination register
//   out_valid  out  1   out_instr valid
//   out_ready  in   1   consumer accepts out_instr
//   out_instr  out  32  encoded instruction word
//   out_last   out  1   final word of the current request's sequence
module li_expander (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Only the low 12 bits of the constant are still needed after capture:
  // they form the immediate of the trailing addi.
  logic [11:0] r_lo12;
  logic [4:0]  r_rd;
  logic [31:0] r_instr;
  logic        r_last;

  logic        w_accept;
  logic        w_outFire;
  logic        w_fits;
  logic [19:0] w_hi20;
  logic [31:0] w_firstInstr;
  logic        w_firstLast;
  logic [31:0] w_secondInstr;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_outFire = out_ready && (r_state != IDLE);

  // A constant fits the addi immediate when bits 31..11 are a pure sign
  // extension of bit 11.
  assign w_fits = (in_value[31:11] == 21'h000000) || (in_value[31:11] == 21'h1FFFFF);

  // Adding bit 11 into the upper part is (value + 0x800) >> 12 with 32-bit
  // wrap: it pre-compensates for addi sign-extending the low 12 bits. The
  // 0x7FFFF800..0x7FFFFFFF range deliberately wraps to 0x80000.
  assign w_hi20 = in_value[31:12] + {19'd0, in_value[11]};

  // First word of the sequence, computed straight from the request inputs
  // so it can be registered on the accepting edge.
  always_comb begin
    w_firstInstr = NOP_INSTR;
    w_firstLast  = 1'b1;
    if (in_rd == 5'd0) begin
      w_firstInstr = NOP_INSTR;
    end else if (w_fits) begin
      w_firstInstr = {in_value[11:0], 5'd0, 3'b000, in_rd, OPC_OP_IMM};
    end else begin
      w_firstInstr = {w_hi20, in_rd, OPC_LUI};
      w_firstLast  = (in_value[11:0] == 12'd0);
    end
  end

  // Trailing addi rd, rd, lo12 built from the captured request.
  assign w_secondInstr = {r_lo12, r_rd, 3'b000, r_rd, OPC_OP_IMM};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = EMIT1;
        end
      end
      EMIT1: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = r_last ? IDLE : EMIT2;
        end
      end
      EMIT2: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output word and request capture. The word registers only change when a
  // state is entered, so they hold steady under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr <= 32'd0;
      r_last  <= 1'b0;
      r_lo12  <= 12'd0;
      r_rd    <= 5'd0;
    end else if (w_accept) begin
      r_instr <= w_firstInstr;
      r_last  <= w_firstLast;
      r_lo12  <= in_value[11:0];
      r_rd    <= in_rd;
    end else if (w_outFire && (r_state == EMIT1) && !r_last) begin
      r_instr <= w_secondInstr;
      r_last  <= 1'b1;
    end
  end

  assign out_instr = r_instr;
  assign out_last  = r_last;

endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander
// Self-checking bench for li_expander: a table of directed vectors with
// hand-derived instruction words, a reset-abort sequence, and randomized
// requests checked against an arithmetic model of the li expansion.
module tb_li_expander;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] gotWords[$];
  logic        gotLast[$];

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    int          stall;
    bit          pulseIn;
    int          nWords;
    logic [31:0] w0;
    logic [31:0] w1;
  } vector_t;

  vector_t vectors[10];

  li_expander dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare a 32-bit value against its required value
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %08h required %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare a single-bit value against its required value
  task automatic checkBit(input string name, input logic actual, input logic expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %b required %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference li expansion written from the arithmetic meaning of the rules
  function automatic int modelWords(input logic [31:0] v, input logic [4:0] rd,
                                    output logic [31:0] w0, output logic [31:0] w1);
    int signed   sv;
    logic [31:0] hi;
    logic [31:0] lo;
    sv = v;
    lo = v & 32'hFFF;
    w0 = 32'h00000013;
    w1 = 32'h0;
    if (rd == 5'd0) return 1;
    if (sv >= -2048 && sv <= 2047) begin
      w0 = (lo << 20) | (32'(rd) << 7) | 32'h13;
      return 1;
    end
    hi = (v + 32'h800) >> 12;
    w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
    if (lo == 32'd0) return 1;
    w1 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
    return 2;
  endfunction

  // Present one request and complete its handshake; the request inputs are
  // scrambled straight afterwards to show they are not sampled again.
  task automatic applyStimulus(input logic [31:0] value, input logic [4:0] rd);
    @(negedge clk);
    checkBit("inReadyIdle", in_ready, 1'b1);
    in_valid = 1'b1;
    in_value = value;
    in_rd    = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = $urandom;
    in_rd    = 5'($urandom_range(0, 31));
  endtask

  // Drain one sequence, stalling each word for 'stall' cycles
  task automatic collectWords(input int stall, input bit pulseIn);
    int          cycles;
    int          stallCnt;
    bit          done;
    logic [31:0] heldInstr;
    logic        heldLast;
    cycles   = 0;
    stallCnt = 0;
    done     = 1'b0;
    heldInstr = 32'h0;
    heldLast  = 1'b0;
    gotWords.delete();
    gotLast.delete();
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      in_valid = 1'b0;
      if (cycles == 1 || gotWords.size() > 0) begin
        checkBit("outValidHigh", out_valid, 1'b1);
      end
      if (!out_valid) begin
        out_ready = 1'b0;
      end else if (stallCnt < stall) begin
        if (stallCnt == 0) begin
          heldInstr = out_instr;
          heldLast  = out_last;
        end else begin
          checkOutput("stallInstr", out_instr, heldInstr);
          checkBit("stallLast", out_last, heldLast);
        end
        if (pulseIn && stallCnt == 1) begin
          in_valid = 1'b1;
          in_value = $urandom;
          in_rd    = 5'd7;
          checkBit("inReadyBusy", in_ready, 1'b0);
        end
        out_ready = 1'b0;
        stallCnt++;
      end else begin
        if (stall > 0) begin
          checkOutput("stallInstr", out_instr, heldInstr);
        end
        out_ready = 1'b1;
        gotWords.push_back(out_instr);
        gotLast.push_back(out_last);
        if (out_last) done = 1'b1;
        stallCnt = 0;
      end
    end
    nChecks++;
    if (!done) begin
      nFails++;
      $display("[TB] FAIL seqDone: got no last word required one within 100 cycles");
    end
  endtask

  // Full request: send, drain, compare words, check idle afterwards
  task automatic runCase(input string name, input logic [31:0] value, input logic [4:0] rd,
                         input int stall, input bit pulseIn, input int nWords,
                         input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] expWord;
    applyStimulus(value, rd);
    collectWords(stall, pulseIn);
    checkOutput({name, ".count"}, 32'(gotWords.size()), 32'(nWords));
    for (int i = 0; i < gotWords.size() && i < nWords; i++) begin
      expWord = (i == 0) ? w0 : w1;
      checkOutput({name, ".word"}, gotWords[i], expWord);
      checkBit({name, ".last"}, gotLast[i], (i == nWords - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checkBit({name, ".inReadyAfter"}, in_ready, 1'b1);
    checkBit({name, ".outValidAfter"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    logic [4:0]  rd;
    logic [31:0] w0;
    logic [31:0] w1;
    int          n;

    vectors[0] = '{32'h00000005, 5'd1, 0, 1'b0, 1, 32'h00500093, 32'h0};
    vectors[1] = '{32'hFFFFFFFF, 5'd2, 0, 1'b0, 1, 32'hFFF00113, 32'h0};
    vectors[2] = '{32'h12345000, 5'd3, 0, 1'b0, 1, 32'h123451B7, 32'h0};
    vectors[3] = '{32'h12345FFF, 5'd5, 0, 1'b0, 2, 32'h123462B7, 32'hFFF28293};
    vectors[4] = '{32'h00000800, 5'd1, 3, 1'b1, 2, 32'h000010B7, 32'h80008093};
    vectors[5] = '{32'h12345FFF, 5'd0, 0, 1'b0, 1, 32'h00000013, 32'h0};
    vectors[6] = '{32'h7FFFFFFF, 5'd4, 1, 1'b0, 2, 32'h80000237, 32'hFFF20213};
    vectors[7] = '{32'h000007FF, 5'd1, 0, 1'b0, 1, 32'h7FF00093, 32'h0};
    vectors[8] = '{32'hFFFFF800, 5'd1, 0, 1'b0, 1, 32'h80000093, 32'h0};
    vectors[9] = '{32'hFFFFF7FF, 5'd1, 2, 1'b0, 2, 32'hFFFFF0B7, 32'h7FF08093};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = 32'h0;
    in_rd     = 5'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkBit("resetOutValid", out_valid, 1'b0);
    checkOutput("resetOutInstr", out_instr, 32'h0);
    checkBit("resetOutLast", out_last, 1'b0);
    checkBit("resetInReady", in_ready, 1'b1);
    reset_n = 1'b1;

    $display("[TB] directed vectors");
    foreach (vectors[i]) begin
      runCase($sformatf("vec%0d", i), vectors[i].value, vectors[i].rd, vectors[i].stall,
              vectors[i].pulseIn, vectors[i].nWords, vectors[i].w0, vectors[i].w1);
    end

    // Reset lands while the second word of a two-word sequence is showing
    $display("[TB] reset mid-sequence");
    applyStimulus(32'h12345FFF, 5'd5);
    @(negedge clk);
    checkBit("abortFirstValid", out_valid, 1'b1);
    checkOutput("abortFirstInstr", out_instr, 32'h123462B7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("abortSecondInstr", out_instr, 32'hFFF28293);
    reset_n = 1'b0;
    @(negedge clk);
    checkBit("abortOutValid", out_valid, 1'b0);
    checkOutput("abortOutInstr", out_instr, 32'h0);
    checkBit("abortOutLast", out_last, 1'b0);
    checkBit("abortInReady", in_ready, 1'b1);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkBit("abortNoStale", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    runCase("afterAbort", 32'h00000005, 5'd1, 0, 1'b0, 1, 32'h00500093, 32'h0);

    $display("[TB] randomized requests");
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: v = r;
        1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: v = {r[31:12], 12'h000};
        default: v = 32'h7FFFF800 + (r & 32'h7FF);
      endcase
      rd = 5'($urandom_range(0, 31));
      n  = modelWords(v, rd, w0, w1);
      runCase($sformatf("rand%0d", k), v, rd, $urandom_range(0, 2), 1'b0, n, w0, w1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test required end before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/li_expander.md
# li_expander

Converts a 32-bit constant plus a destination register number into the RV32I instruction sequence that rebuilds it: the `li` pseudo-instruction expansion. It is the encoding counterpart of the decode-side immediate sign-extender. Each constant becomes one or two instruction words.
- Fits in signed 12 bits: one `addi`.
- Otherwise: `lui`, optionally followed by `addi`.

The block sits between the test/boot loader and instruction memory. It is fed by a valid/ready request port and drains through a valid/ready instruction port.

## Interface
Parameters: none (fixed RV32I encoding).

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request
- `in_value`  in  32  constant to load
- `in_rd`  in  5  destination register
- `out_valid`  out  1  `out_instr` valid
- `out_ready`  in  1  consumer accepts `out_instr`
- `out_instr`  out  32  encoded instruction word
- `out_last`  out  1  marks final word of the current request's sequence

## Operation
- **Request capture:** on `in_valid && in_ready`, capture `in_value` and `in_rd` into registers `val` and `rd`.
- **Fit test:** the value fits when `val[31:11]` is all 0s or all 1s.
- **Split (no-fit case):**
  - `lo12 = val[11:0]`.
  - `hi20 = (val + 32'h800) >> 12`, computed with 32-bit wrap. This pre-compensates for `addi` sign-extending `lo12`.
- **Encodings:**
  - `addi`: `{imm12, rs1, 3'b000, rd, 7'b0010011}`.
  - `lui`: `{imm20, rd, 7'b0110111}`.
- **Sequences:**
  - Fits: `addi rd, x0, val[11:0]`, `out_last = 1`.
  - No fit, `lo12 == 0`: `lui rd, hi20`, `out_last = 1`.
  - No fit, `lo12 != 0`:
    - `lui rd, hi20` with `out_last = 0`.
    - then `addi rd, rd, lo12` with `out_last = 1`.
- **`rd == 0`:** emit the single word `addi x0, x0, 0` (`32'h00000013`), `out_last = 1`, regardless of value.
- **FSM states:** IDLE, EMIT1, EMIT2.
  - IDLE → EMIT1 on accept.
  - EMIT1 → IDLE on output handshake if the word is last; otherwise EMIT1 → EMIT2.
  - EMIT2 → IDLE on output handshake.
- **Output registers:** `out_instr` and `out_last` are registered, loaded on entry to EMIT1/EMIT2.

## Timing
- **Reset values:** state = IDLE, `out_valid = 0`, `out_instr = 0`, `out_last = 0`, `in_ready = 1`.
- **`in_ready`:** high exactly when state is IDLE. There is no overlap between requests.
- **Latency:** the first word's `out_valid` rises the cycle after the input handshake.
- **Second word:** for two-word sequences, it is presented the cycle after the first word's handshake. `out_valid` stays high continuously across both words.
- **Backpressure:** while `out_valid && !out_ready`, `out_instr` and `out_last` are held stable and state does not change.
- **Back-to-back requests:** `in_ready` returns high the cycle after the last word's handshake. Best sustained rate is one request per 2 cycles (single-word) or per 3 cycles (two-word).
- **Ignored inputs:**
  - `in_valid` while not IDLE.
  - `in_value`/`in_rd` changes after capture.
- **Reset mid-sequence:** `reset_n = 0` at any clock edge aborts the sequence. Any pending second word is discarded; all outputs return to their reset values next cycle.
- **Wrap case:** `val = 32'h7FFFF800..7FFFFFFF` wraps `hi20` to `0x80000`. The resulting sequence is still correct modulo 2^32 and must not be special-cased.

## Test plan
- `value=5`, `rd=1` → single word `0x00500093`, `out_last=1`; `in_ready` high again 1 cycle after its handshake.
- `value=0xFFFFFFFF`, `rd=2` → single word `0xFFF00113` (fits, negative).
- `value=0x12345000`, `rd=3` → single `lui` `0x123451B7`, `out_last=1`.
- `value=0x12345FFF`, `rd=5` → two words:
  - `0x123462B7` (`out_last=0`);
  - then `0xFFF28293` (`out_last=1`).
  - Check that hi20 rounding is applied.
- `value=0x00000800`, `rd=1`, with `out_ready` held low 3 cycles on each word → two words:
  - `0x000010B7`, then `0x80008093`;
  - both held stable during stall;
  - `in_valid` pulsed mid-sequence is ignored.
- `value=0x12345FFF`, `rd=0`, then reset asserted after the first word of a new two-word request → `0x00000013` emitted alone; after reset all outputs are 0, `in_ready=1`, and no stale second word appears.
